// File: rtl/dbus_pkg.sv
// Shared encodings, fault causes, FSM states and the alignment check for the
// external data bus initiator.
package dbus_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_ACCESS    = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_ACCESS   = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Size 2'b11 falls through to the byte case, which never misaligns.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SZ_WORD: return addr_lo != 2'b00;
      SZ_HALF: return addr_lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Store lane placement onto the bus and sign/zero extension of load data;
// both sides are right-justified.
module dbus_lane_align
  import dbus_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic [1:0]           st_size,
  input  logic [BIT_WIDTH-1:0] st_wdata,
  output logic [BIT_WIDTH-1:0] st_lanes,
  input  logic [1:0]           ld_size,
  input  logic                 ld_unsigned,
  input  logic [BIT_WIDTH-1:0] ld_bus,
  output logic [BIT_WIDTH-1:0] ld_data
);

  always_comb begin
    st_lanes = '0;
    case (st_size)
      SZ_WORD: st_lanes = st_wdata;
      SZ_HALF: st_lanes[15:0] = st_wdata[15:0];
      default: st_lanes[7:0] = st_wdata[7:0];
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (ld_size)
      SZ_WORD: ld_data = ld_bus;
      SZ_HALF: ld_data = {{(BIT_WIDTH-16){~ld_unsigned & ld_bus[15]}}, ld_bus[15:0]};
      default: ld_data = {{(BIT_WIDTH-8){~ld_unsigned & ld_bus[7]}}, ld_bus[7:0]};
    endcase
  end

endmodule

// File: rtl/dbus_master.sv
// Core-side data bus initiator: accepts one aligned load/store, runs a bus
// cycle until ACKD_n or timeout, then returns extended data or a fault.
module dbus_master
  import dbus_pkg::*;
#(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [3:0]           resp_cause,
  output logic [BIT_WIDTH-1:0] DAD,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n
);

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e               state_q, state_d;
  logic                 mreq_q, mreq_d;
  logic                 write_q, write_d;
  logic [1:0]           size_q, size_d;
  logic [BIT_WIDTH-1:0] dad_q, dad_d;
  logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic                 uns_q, uns_d;
  logic [CNT_W-1:0]     tcnt_q, tcnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [3:0]           resp_cause_q, resp_cause_d;
  logic [BIT_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [BIT_WIDTH-1:0] st_lanes;
  logic [BIT_WIDTH-1:0] ld_data;
  logic                 ddt_oe;
  logic                 expired;

  dbus_lane_align #(.BIT_WIDTH(BIT_WIDTH)) u_lane_align (
    .st_size     (req_size),
    .st_wdata    (req_wdata),
    .st_lanes    (st_lanes),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_bus      (DDT),
    .ld_data     (ld_data)
  );

  assign ddt_oe  = (state_q == ST_BUS) && write_q;
  assign DDT     = ddt_oe ? wdata_q : 'z;
  assign expired = TIMEOUT_EN && ((32'(tcnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_cause = resp_cause_q;
  assign resp_rdata = resp_rdata_q;
  assign MREQ       = mreq_q;
  assign WRITE      = write_q;
  assign SIZE       = size_q;
  assign DAD        = dad_q;

  always_comb begin
    state_d      = state_q;
    mreq_d       = mreq_q;
    write_d      = write_q;
    size_d       = size_q;
    dad_d        = dad_q;
    wdata_d      = wdata_q;
    uns_d        = uns_q;
    tcnt_d       = tcnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_cause_d = 4'd0;
    resp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_cause_d = req_write ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
          end else begin
            state_d = ST_BUS;
            mreq_d  = 1'b1;
            write_d = req_write;
            size_d  = req_size;
            dad_d   = req_addr;
            wdata_d = st_lanes;
            uns_d   = req_unsigned;
            tcnt_d  = '0;
          end
        end
      end
      ST_BUS: begin
        // An ack on the expiry edge still completes the access normally.
        if (!ACKD_n) begin
          state_d      = ST_RESP;
          mreq_d       = 1'b0;
          write_d      = 1'b0;
          tcnt_d       = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? '0 : ld_data;
        end else if (expired) begin
          state_d      = ST_RESP;
          mreq_d       = 1'b0;
          write_d      = 1'b0;
          tcnt_d       = '0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_cause_d = write_q ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
        end else if (TIMEOUT_EN) begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mreq_q       <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= SZ_WORD;
      dad_q        <= '0;
      wdata_q      <= '0;
      uns_q        <= 1'b0;
      tcnt_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_cause_q <= 4'd0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mreq_q       <= mreq_d;
      write_q      <= write_d;
      size_q       <= size_d;
      dad_q        <= dad_d;
      wdata_q      <= wdata_d;
      uns_q        <= uns_d;
      tcnt_q       <= tcnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_cause_q <= resp_cause_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_dbus_master.sv
// Directed bench for dbus_master: a responder model drives ACKD_n/DDT, a
// scoreboard queue holds expected responses and a monitor checks them.
module tb_dbus_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  cause;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  resp_cause;
  logic [31:0] DAD;
  wire  [31:0] ddt;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n = 1'b1;

  logic        tb_oe = 1'b0;
  logic [31:0] tb_ddt = '0;
  assign ddt = tb_oe ? tb_ddt : 'z;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  int          rsp_delay = 0;
  logic        rsp_ack_en = 1'b0;
  logic [31:0] rsp_data = '0;
  int          bus_cycles = 0;

  dbus_master #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .resp_cause   (resp_cause),
    .DAD          (DAD),
    .DDT          (ddt),
    .MREQ         (MREQ),
    .WRITE        (WRITE),
    .SIZE         (SIZE),
    .ACKD_n       (ACKD_n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkReleased(input string name);
    n_checks++;
    if (!((ddt === 32'hzzzz_zzzz) || (ddt === 32'h0))) begin
      n_fail++;
      $display("[TB] FAIL %s: DDT=%h, expected released", name, ddt);
    end
  endtask

  // Responder: acks after rsp_delay extra BUS cycles, presenting load data.
  always @(negedge clk) begin
    if (MREQ && rsp_ack_en) begin
      if (bus_cycles == rsp_delay) begin
        ACKD_n = 1'b0;
        if (!WRITE) begin
          tb_oe  = 1'b1;
          tb_ddt = rsp_data;
        end
      end else begin
        ACKD_n = 1'b1;
        tb_oe  = 1'b0;
      end
      bus_cycles++;
    end else begin
      ACKD_n     = 1'b1;
      tb_oe      = 1'b0;
      bus_cycles = 0;
    end
  end

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && resp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("resp_rdata", resp_rdata, e.rdata);
        checkOutput("resp_err", 32'(resp_err), 32'(e.err));
        checkOutput("resp_cause", 32'(resp_cause), 32'(e.cause));
        checkOutput("req_ready_in_resp", 32'(req_ready), 32'd0);
      end
    end
  end

  task automatic waitReady();
    int c;
    c = 0;
    while (!req_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL ready_wait: got req_ready=0, expected 1 within 20 cycles");
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic ack_en, input int delay, input logic [31:0] bus_data,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input logic [3:0] exp_cause, input int exp_mreq,
                               input logic [31:0] exp_ddt);
    exp_t e;
    int   mreq_cycles;
    bit   done;
    @(negedge clk);
    waitReady();
    rsp_ack_en   = ack_en;
    rsp_delay    = delay;
    rsp_data     = bus_data;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cause = exp_cause;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    mreq_cycles = 0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (MREQ) begin
        mreq_cycles++;
        checkOutput("dad", DAD, addr);
        checkOutput("size", 32'(SIZE), 32'(sz));
        checkOutput("write", 32'(WRITE), 32'(wr));
        if (wr) checkOutput("ddt_store", ddt, exp_ddt);
      end
      if (resp_valid) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL resp_wait: got no resp_valid, expected one within 20 cycles");
    end
    checkOutput("mreq_cycles", 32'(mreq_cycles), 32'(exp_mreq));
    rsp_ack_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mreq", 32'(MREQ), 32'd0);
    checkOutput("rst_write", 32'(WRITE), 32'd0);
    checkOutput("rst_size", 32'(SIZE), 32'd0);
    checkOutput("rst_dad", DAD, 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_resp_cause", 32'(resp_cause), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkReleased("rst_ddt");
    rst = 1'b1;

    // wr sz uns addr wdata ack delay busdata | rdata err cause mreq ddt
    applyStimulus(0, 2'b00, 0, 32'h0800_0010, 32'h0, 1, 0, 32'hDEAD_BEEF,
                  32'hDEAD_BEEF, 0, 4'd0, 1, 32'h0);
    applyStimulus(0, 2'b10, 0, 32'h0800_0003, 32'h0, 1, 0, 32'h0000_00F0,
                  32'hFFFF_FFF0, 0, 4'd0, 1, 32'h0);
    applyStimulus(0, 2'b10, 1, 32'h0800_0003, 32'h0, 1, 0, 32'h0000_00F0,
                  32'h0000_00F0, 0, 4'd0, 1, 32'h0);
    applyStimulus(0, 2'b01, 0, 32'h0800_0006, 32'h0, 1, 3, 32'h0000_8001,
                  32'hFFFF_8001, 0, 4'd0, 4, 32'h0);
    applyStimulus(0, 2'b01, 1, 32'h0800_0006, 32'h0, 1, 1, 32'h0000_8001,
                  32'h0000_8001, 0, 4'd0, 2, 32'h0);
    applyStimulus(1, 2'b10, 0, 32'hF000_0000, 32'h1234_5641, 1, 0, 32'h0,
                  32'h0, 0, 4'd0, 1, 32'h0000_0041);
    applyStimulus(1, 2'b01, 0, 32'h0800_0012, 32'hAAAA_9876, 1, 2, 32'h0,
                  32'h0, 0, 4'd0, 3, 32'h0000_9876);
    applyStimulus(1, 2'b00, 0, 32'hFF00_0000, 32'h0000_0001, 1, 0, 32'h0,
                  32'h0, 0, 4'd0, 1, 32'h0000_0001);
    applyStimulus(0, 2'b00, 0, 32'h0800_0002, 32'h0, 1, 0, 32'h1111_1111,
                  32'h0, 1, 4'd4, 0, 32'h0);
    applyStimulus(1, 2'b01, 0, 32'h0800_0001, 32'h5555_5555, 1, 0, 32'h0,
                  32'h0, 1, 4'd6, 0, 32'h0);
    applyStimulus(1, 2'b00, 0, 32'h0800_0020, 32'hCAFE_F00D, 0, 0, 32'h0,
                  32'h0, 1, 4'd7, 4, 32'hCAFE_F00D);
    applyStimulus(0, 2'b00, 0, 32'h0800_0024, 32'h0, 0, 0, 32'h0,
                  32'h0, 1, 4'd5, 4, 32'h0);

    // Reset while a store is on the bus abandons it without a response.
    @(negedge clk);
    waitReady();
    rsp_ack_en = 1'b0;
    req_write  = 1'b1;
    req_size   = 2'b10;
    req_addr   = 32'h0800_0040;
    req_wdata  = 32'h0000_00A5;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_mreq_before", 32'(MREQ), 32'd1);
    checkOutput("midrst_ddt_before", ddt, 32'h0000_00A5);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_mreq", 32'(MREQ), 32'd0);
    checkOutput("midrst_write", 32'(WRITE), 32'd0);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
    checkReleased("midrst_ddt");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus(0, 2'b00, 0, 32'h0800_0044, 32'h0, 1, 0, 32'h0BAD_F00D,
                  32'h0BAD_F00D, 0, 4'd0, 1, 32'h0);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_master.md
Name: dbus_master

Overview:
- Core-side initiator for the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). The testbench memory model acts as the responder on this bus.
- Accepts one load/store request at a time from the MEM stage and checks alignment. It then drives a bus cycle, waits on ACKD_n, and returns sign/zero-extended load data or a fault.
- The MEM stage holds the pipeline stalled while a request is outstanding.

Parameters:
- BIT_WIDTH, 32, address/data width.
- TIMEOUT_CYCLES, 255, bus cycles to wait for ACKD_n before reporting an access fault. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-low.
- req_valid  in  1  MEM-stage request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 half, 10 byte (11 treated as byte).
- req_unsigned  in  1  zero-extend load result (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_err  out  1  fault flag, qualified by resp_valid.
- resp_cause  out  4  4 load-misaligned, 5 load-access, 6 store-misaligned, 7 store-access.
- DAD  out  32  bus address.
- DDT  inout  32  bus data.
- MREQ  out  1  bus request.
- WRITE  out  1  bus direction.
- SIZE  out  2  bus transfer size.
- ACKD_n  in  1  responder acknowledge, active-low.

Behaviour:
- Reset (rst==0 at a rising edge): state IDLE.
  - MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT released (Z).
  - resp_valid=0, resp_err=0, resp_cause=0, resp_rdata=0, timeout counter=0.
- Reset mid-cycle: any bus cycle is abandoned at that edge. No response is produced.
- States: IDLE, BUS, RESP.
- Acceptance: a request is accepted at a rising edge when req_valid & req_ready. All bus outputs are registered.
- Misaligned request: size 00 with addr[1:0]!=0, or size 01 with addr[0]!=0.
  - No bus cycle is issued; go to RESP.
  - Next cycle: resp_valid=1, resp_err=1, cause 4 (load) or 6 (store).
- Aligned request, on the accepting edge:
  - Load MREQ=1, WRITE=req_write, SIZE=req_size, DAD=req_addr; go to BUS.
  - Store data lane placement on DDT:
    - word: DDT[31:0] = wdata.
    - half: DDT[15:0] = wdata[15:0], upper bits 0.
    - byte: DDT[7:0] = wdata[7:0], upper bits 0.
  - DDT is driven only while in BUS with WRITE=1; otherwise it is Z.
- BUS state:
  - Bus outputs hold stable.
  - At each rising edge, if ACKD_n==0:
    - Capture DDT for loads.
    - Drop MREQ and WRITE and release DDT.
    - Go to RESP.
- Load extension of the captured DDT, bus data right-justified:
  - byte: DDT[7:0], sign- or zero-extended.
  - half: DDT[15:0], sign- or zero-extended.
  - word: unchanged.
- Timeout:
  - The counter increments per BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, drop MREQ and go to RESP with err, cause 5 (load) or 7 (store).
  - If ack and expiry occur on the same edge, ack wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready returns high the cycle after RESP.
- Minimum latency:
  - Accept at edge 0, MREQ visible in cycle 1, ack sampled at edge 1, resp_valid in cycle 2.
  - Throughput: one access per 3 cycles.
- ACKD_n low outside BUS is ignored.
- STDOUT (0xF000_0000) and EXIT (0xFF00_0000) are ordinary store addresses to this block.

Decomposition:
- Shared package dbus_pkg:
  - SIZE encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - Cause constants 4/5/6/7.
  - FSM state enum.
  - Alignment-check function.
- One combinational sub-module dbus_lane_align: store lane placement and load sign/zero extension. The FSM, counter and tri-state control stay in dbus_master.

Test Plan:
- Word load, addr 0x0800_0010, responder returns 0xDEADBEEF with 1-cycle latency:
  - MREQ=1, WRITE=0, SIZE=00 in cycle 1.
  - resp_valid in cycle 2 with rdata 0xDEADBEEF, err=0.
- Byte load, addr 0x0800_0003, DDT=0x000000F0:
  - signed: rdata 0xFFFFFFF0.
  - req_unsigned=1: rdata 0x000000F0.
- Half load, responder delays ACKD_n 3 extra cycles, DDT=0x00008001:
  - MREQ, DAD and SIZE stable throughout.
  - rdata 0xFFFF8001 one cycle after the ack edge.
- Byte store 0x12345641 to 0xF000_0000: DDT=0x00000041 while WRITE=1; resp err=0, rdata 0.
- Misaligned:
  - Word load at 0x0800_0002: no MREQ, resp err=1, cause 4.
  - Half store at 0x0800_0001: err=1, cause 6.
- TIMEOUT_CYCLES=4, ACKD_n held high on a store: MREQ drops after 4 BUS cycles, err=1, cause 7.
- Separately, rst=0 asserted mid-BUS: MREQ=0 and DDT=Z next cycle, no resp_valid, req_ready=1.
